trap_sequencer: RTL

- Multi-cycle, parametrised successor to the single-cycle trap path.
- Sequences machine-mode trap entry and MRET return through the CSR file's single CSR port. Handles synchronous exceptions plus NUM_IRQ level-sensitive interrupt lines, with direct or vectored mtvec.
- Sits between the exception detector, the CSR file and the PC controller.
- Holds the core stalled via busy until trap_done.

---
 rtl/trap_sequencer.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/trap_sequencer.sv
// Multi-cycle M-mode trap entry / MRET sequencer driving the CSR file's single port.
// Entry: 7 cycles from acceptance to trap_done; MRET: 4. Requests are ignored while busy.
module trap_sequencer #(
  parameter int XLEN           = 32,
  parameter int NUM_IRQ        = 4,
  parameter int IRQ_CAUSE_BASE = 16,
  parameter bit VECTORED_EN    = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               exception_valid,
  input  logic [4:0]         exception_cause,
  input  logic [XLEN-1:0]    exception_tval,
  input  logic               mret,
  input  logic [XLEN-1:0]    pc,
  input  logic [NUM_IRQ-1:0] irq_pending,
  input  logic [NUM_IRQ-1:0] irq_enable,
  input  logic [XLEN-1:0]    csr_read_data,
  output logic               busy,
  output logic               csr_write_enable,
  output logic [11:0]        csr_address,
  output logic [XLEN-1:0]    csr_write_data,
  output logic [XLEN-1:0]    trap_target,
  output logic               trap_done
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_MEPC, S_WR_MCAUSE, S_WR_MTVAL, S_RD_MSTATUS,
    S_WR_MSTATUS, S_RD_MTVEC, S_RD_MEPC, S_DONE
  } state_t;

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MTVAL   = 12'h343;

  state_t            state_q, state_d;
  logic              is_mret_q, is_mret_d;
  logic [XLEN-1:0]   epc_q, epc_d;
  logic [XLEN-1:0]   cause_q, cause_d;
  logic [XLEN-1:0]   tval_q, tval_d;
  logic [XLEN-1:0]   ms_q, ms_d;
  logic [XLEN-1:0]   target_q, target_d;
  logic              busy_q, busy_d;
  logic              we_q, we_d;
  logic [11:0]       addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   trap_target_q, trap_target_d;
  logic              trap_done_q, trap_done_d;

  logic [NUM_IRQ-1:0] irq_hit;
  logic [4:0]         irq_code;
  logic               irq_take;
  logic [XLEN-1:0]    base;
  logic [XLEN-1:0]    vec_off;
  logic [XLEN-1:0]    ms_wr;

  // MIE is only trusted once the registered address really points at mstatus
  // (the first cycle after reset still presents address 0).
  always_comb begin
    irq_hit  = irq_pending & irq_enable;
    irq_code = 5'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (irq_hit[i]) irq_code = 5'(IRQ_CAUSE_BASE + i);
    end
    irq_take = csr_read_data[3] && (addr_q == A_MSTATUS) && (|irq_hit);
  end

  always_comb begin
    state_d   = state_q;
    is_mret_d = is_mret_q;
    epc_d     = epc_q;
    cause_d   = cause_q;
    tval_d    = tval_q;
    ms_d      = ms_q;
    target_d  = target_q;
    base      = {csr_read_data[XLEN-1:2], 2'b00};
    vec_off   = '0;
    vec_off[6:0] = {cause_q[4:0], 2'b00};

    case (state_q)
      S_IDLE: begin
        if (exception_valid) begin
          state_d   = S_WR_MEPC;
          is_mret_d = 1'b0;
          epc_d     = pc;
          cause_d   = {1'b0, {(XLEN-6){1'b0}}, exception_cause};
          tval_d    = exception_tval;
        end else if (mret) begin
          state_d   = S_RD_MSTATUS;
          is_mret_d = 1'b1;
        end else if (irq_take) begin
          state_d   = S_WR_MEPC;
          is_mret_d = 1'b0;
          epc_d     = pc;
          cause_d   = {1'b1, {(XLEN-6){1'b0}}, irq_code};
          tval_d    = '0;
        end
      end
      S_WR_MEPC:    state_d = S_WR_MCAUSE;
      S_WR_MCAUSE:  state_d = S_WR_MTVAL;
      S_WR_MTVAL:   state_d = S_RD_MSTATUS;
      S_RD_MSTATUS: begin
        ms_d    = csr_read_data;
        state_d = S_WR_MSTATUS;
      end
      S_WR_MSTATUS: state_d = is_mret_q ? S_RD_MEPC : S_RD_MTVEC;
      S_RD_MTVEC: begin
        if (VECTORED_EN && (csr_read_data[1:0] == 2'b01) && cause_q[XLEN-1])
          target_d = base + vec_off;
        else
          target_d = base;
        state_d = S_DONE;
      end
      S_RD_MEPC: begin
        target_d = base;
        state_d  = S_DONE;
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    ms_wr = ms_d;
    ms_wr[12:11] = 2'b11;
    if (is_mret_d) begin
      ms_wr[3] = ms_d[7];
      ms_wr[7] = 1'b1;
    end else begin
      ms_wr[7] = ms_d[3];
      ms_wr[3] = 1'b0;
    end

    // Outputs are decoded from the next state so they register alongside it.
    busy_d        = (state_d != S_IDLE);
    we_d          = 1'b0;
    addr_d        = 12'h000;
    wdata_d       = '0;
    trap_target_d = '0;
    trap_done_d   = 1'b0;
    case (state_d)
      S_IDLE:       addr_d = A_MSTATUS;
      S_WR_MEPC:    begin we_d = 1'b1; addr_d = A_MEPC;    wdata_d = {epc_d[XLEN-1:2], 2'b00}; end
      S_WR_MCAUSE:  begin we_d = 1'b1; addr_d = A_MCAUSE;  wdata_d = cause_d; end
      S_WR_MTVAL:   begin we_d = 1'b1; addr_d = A_MTVAL;   wdata_d = tval_d; end
      S_RD_MSTATUS: addr_d = A_MSTATUS;
      S_WR_MSTATUS: begin we_d = 1'b1; addr_d = A_MSTATUS; wdata_d = ms_wr; end
      S_RD_MTVEC:   addr_d = A_MTVEC;
      S_RD_MEPC:    addr_d = A_MEPC;
      S_DONE:       begin trap_done_d = 1'b1; trap_target_d = target_d; end
      default:      addr_d = 12'h000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      is_mret_q     <= 1'b0;
      epc_q         <= '0;
      cause_q       <= '0;
      tval_q        <= '0;
      ms_q          <= '0;
      target_q      <= '0;
      busy_q        <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= 12'h000;
      wdata_q       <= '0;
      trap_target_q <= '0;
      trap_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      is_mret_q     <= is_mret_d;
      epc_q         <= epc_d;
      cause_q       <= cause_d;
      tval_q        <= tval_d;
      ms_q          <= ms_d;
      target_q      <= target_d;
      busy_q        <= busy_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      trap_target_q <= trap_target_d;
      trap_done_q   <= trap_done_d;
    end
  end

  assign busy             = busy_q;
  assign csr_write_enable = we_q;
  assign csr_address      = addr_q;
  assign csr_write_data   = wdata_q;
  assign trap_target      = trap_target_q;
  assign trap_done        = trap_done_q;

endmodule
